// File: rtl/dec_onehot_seq.sv
// rtl/dec_onehot_seq.sv - registered N-to-2**N one-hot decoder with load/step/auto-scan index
module dec_onehot_seq #(
  parameter int N   = 3,
  parameter int DIV = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    x,
  input  logic            ld,
  input  logic            step,
  input  logic            dir,
  input  logic            auto_scan,
  input  logic            en,
  output logic [2**N-1:0] y,
  output logic [N-1:0]    idx,
  output logic            wrap
);

  localparam int              CW       = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0]   CNT_LAST = CW'(DIV - 1);
  localparam logic [N-1:0]    IDX_MAX  = '1;

  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cnt_next;
  logic            tick;
  logic            step_eff;
  logic [N-1:0]    idx_next;
  logic [2**N-1:0] y_next;
  logic            wrap_next;

  always_comb begin
    tick      = auto_scan & ~ld & (cnt == CNT_LAST);
    cnt_next  = '0;
    if (auto_scan && !ld && !tick) begin
      cnt_next = cnt + 1'b1;
    end

    // Step and tick are OR'd so a coincident pair advances the index only once.
    step_eff  = step | tick;
    idx_next  = idx;
    wrap_next = 1'b0;
    if (ld) begin
      idx_next = x;
    end else if (step_eff) begin
      idx_next  = dir ? idx + 1'b1 : idx - 1'b1;
      wrap_next = dir ? (idx == IDX_MAX) : (idx == '0);
    end

    y_next = '0;
    if (en) begin
      y_next[idx_next] = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt  <= '0;
      idx  <= '0;
      y    <= '0;
      wrap <= 1'b0;
    end else begin
      cnt  <= cnt_next;
      idx  <= idx_next;
      y    <= y_next;
      wrap <= wrap_next;
    end
  end

endmodule

// File: tb/tb_dec_onehot_seq.sv
// tb/tb_dec_onehot_seq.sv - scoreboard bench for dec_onehot_seq (N=3, DIV=4)
module tb_dec_onehot_seq;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [2:0] x;
  logic       ld, step, dir, auto_scan, en;
  logic [7:0] y;
  logic [2:0] idx;
  logic       wrap;

  typedef struct packed {
    logic [7:0] y;
    logic [2:0] idx;
    logic       wrap;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   total = 0;
  int   bad   = 0;

  dec_onehot_seq #(.N(3), .DIV(4)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .ld(ld), .step(step), .dir(dir),
    .auto_scan(auto_scan), .en(en), .y(y), .idx(idx), .wrap(wrap)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] req);
    total++;
    if (act !== req) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, req, $time);
    end
  endtask

  // Drive one cycle; expected post-edge state is queued once the edge has happened.
  task automatic cyc(input logic l, input logic [2:0] xv, input logic s, input logic d,
                     input logic a, input logic en_v, input logic [2:0] ei, input logic ew);
    exp_t ex;
    x = xv; ld = l; step = s; dir = d; auto_scan = a; en = en_v;
    ex.idx  = rst_n ? ei : 3'd0;
    ex.wrap = rst_n ? ew : 1'b0;
    ex.y    = (rst_n && en_v) ? (8'h01 << ei) : 8'h00;
    @(posedge clk);
    #1;
    q.push_back(ex);
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("y", y, e.y);
      chk("idx", {5'd0, idx}, {5'd0, e.idx});
      chk("wrap", {7'd0, wrap}, {7'd0, e.wrap});
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    x = '0; ld = 0; step = 0; dir = 0; auto_scan = 0; en = 0;
    for (int i = 0; i < 3; i++)
      cyc(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
          1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 3'd0, 1'b0);
    rst_n = 1'b1;

    cyc(0, 0, 0, 0, 0, 1, 3'd0, 0);
    cyc(1, 5, 0, 0, 0, 1, 3'd5, 0);
    // wrap up then down
    cyc(1, 7, 0, 0, 0, 1, 3'd7, 0);
    cyc(0, 0, 1, 1, 0, 1, 3'd0, 1);
    cyc(0, 0, 1, 0, 0, 1, 3'd7, 1);
    cyc(0, 0, 0, 0, 0, 1, 3'd7, 0);
    // load beats step; load never wraps
    cyc(1, 2, 1, 1, 0, 1, 3'd2, 0);
    cyc(1, 0, 0, 0, 0, 1, 3'd0, 0);
    cyc(1, 7, 1, 0, 0, 1, 3'd7, 0);
    // disabled outputs while stepping
    cyc(1, 2, 0, 0, 0, 1, 3'd2, 0);
    cyc(0, 0, 1, 1, 0, 0, 3'd3, 0);
    cyc(0, 0, 1, 1, 0, 0, 3'd4, 0);
    cyc(0, 0, 1, 1, 0, 0, 3'd5, 0);
    cyc(0, 0, 0, 1, 0, 1, 3'd5, 0);
    // auto-scan from 0: step every 4 cycles, wrap at cycle 32
    cyc(1, 0, 0, 0, 0, 1, 3'd0, 0);
    for (int k = 1; k <= 40; k++)
      cyc(0, 0, 0, 1, 1, 1, 3'((k / 4) % 8), (k % 32) == 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd2, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd2, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd2, 0);
    cyc(0, 0, 1, 1, 1, 1, 3'd3, 0);
    cyc(0, 0, 1, 1, 1, 1, 3'd4, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd4, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd4, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd5, 0);
    // reset mid-scan
    cyc(1, 6, 0, 1, 1, 1, 3'd6, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd6, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd6, 0);
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("async_rst_y", y, 8'h00);
    chk("async_rst_idx", {5'd0, idx}, 8'h00);
    cyc(0, 0, 0, 1, 1, 1, 3'd0, 0);
    rst_n = 1'b1;
    cyc(0, 0, 0, 1, 1, 1, 3'd0, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd0, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd0, 0);
    cyc(0, 0, 0, 1, 1, 1, 3'd1, 0);

    @(negedge clk);
    #1;
    chk("queue_drained", 8'(q.size()), 8'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
